// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the ID-stage hazard control unit: FSM states, register-zero
// constant and the packed control-output bundle with its three canonical settings.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLdStall = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic mux_nop;
        logic flush;
    } ctrl_t;

    localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, mux_nop: 1'b1, flush: 1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, mux_nop: 1'b0, flush: 1'b1};
    localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, mux_nop: 1'b0, flush: 1'b0};

endpackage

// File: rtl/hazard_reg_match.sv
// Flags when a producer destination register is read by any valid ID source operand.
// Register zero never matches.
module hazard_reg_match
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned NUM_SRC = 2
) (
    input  logic [REG_W-1:0]         rd,
    input  logic [NUM_SRC*REG_W-1:0] srcs,
    input  logic [NUM_SRC-1:0]       valids,
    output logic                     match
);

    always_comb begin
        match = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (valids[k] && (srcs[k*REG_W +: REG_W] == rd)) begin
                match = 1'b1;
            end
        end
        if (rd == REG_W'(REG_ZERO)) begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage stall/flush control: load-use and branch-operand hazard detection,
// multi-cycle load stalls and front-end flushes, saturating perf counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PERF_W       = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_SRC*REG_W-1:0] if_id_src_in,
    input  logic [NUM_SRC-1:0]       if_id_src_valid_in,
    input  logic [REG_W-1:0]         id_ex_rd_in,
    input  logic                     id_ex_mem_read_in,
    input  logic                     id_ex_reg_write_in,
    input  logic [REG_W-1:0]         ex_mem_rd_in,
    input  logic                     ex_mem_mem_read_in,
    input  logic                     branch_in,
    input  logic                     jump_in,
    input  logic                     comparator_in,
    input  logic                     perf_clear_in,
    output logic                     pc_write_out,
    output logic                     if_id_write_out,
    output logic                     mux_nop_out,
    output logic                     flush_out,
    output logic [PERF_W-1:0]        stall_cycles_out,
    output logic [PERF_W-1:0]        flush_cycles_out
);

    localparam int unsigned MAX_CYC = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_CYCLES - 1);

    logic id_ex_match, ex_mem_match;
    logic hz_ld, hz_br, redirect;

    hazard_reg_match #(.REG_W(REG_W), .NUM_SRC(NUM_SRC)) u_match_id_ex (
        .rd     (id_ex_rd_in),
        .srcs   (if_id_src_in),
        .valids (if_id_src_valid_in),
        .match  (id_ex_match)
    );

    hazard_reg_match #(.REG_W(REG_W), .NUM_SRC(NUM_SRC)) u_match_ex_mem (
        .rd     (ex_mem_rd_in),
        .srcs   (if_id_src_in),
        .valids (if_id_src_valid_in),
        .match  (ex_mem_match)
    );

    // A jump has no operands to wait on, so it masks any branch-operand hazard.
    assign hz_ld    = id_ex_mem_read_in & id_ex_match;
    assign hz_br    = branch_in & ~jump_in &
                      ((id_ex_reg_write_in & id_ex_match) | (ex_mem_mem_read_in & ex_mem_match));
    assign redirect = jump_in | (branch_in & comparator_in & ~hz_br);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_NORMAL;
        unique case (state_q)
            StRun: begin
                if (hz_ld) begin
                    ctrl = CTRL_STALL;
                    if (LOAD_LAT > 1) begin
                        state_d = StLdStall;
                        cnt_d   = LD_INIT;
                    end
                end else if (hz_br) begin
                    ctrl = CTRL_STALL;
                end else if (redirect) begin
                    ctrl = CTRL_FLUSH;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        cnt_d   = FL_INIT;
                    end
                end
            end
            StLdStall, StFlush: begin
                ctrl  = (state_q == StLdStall) ? CTRL_STALL : CTRL_FLUSH;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StRun;
                end
            end
            default: begin
                ctrl    = CTRL_STALL;
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
        if (!rst_n_in) begin
            ctrl = CTRL_STALL;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [PERF_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (perf_clear_in) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (ctrl.flush && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign pc_write_out     = ctrl.pc_write;
    assign if_id_write_out  = ctrl.if_id_write;
    assign mux_nop_out      = ctrl.mux_nop;
    assign flush_out        = ctrl.flush;
    assign stall_cycles_out = stall_q;
    assign flush_cycles_out = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two configurations (single-cycle with 3-bit counters, and
// LOAD_LAT=3 / FLUSH_CYCLES=2) driven with the same stimulus against a reference model.
module tb_hazard_control_unit;

    localparam logic [3:0] STALL_C  = 4'b0010;
    localparam logic [3:0] FLUSH_C  = 4'b1101;
    localparam logic [3:0] NORMAL_C = 4'b1100;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_n_in;
    logic [4:0] src0, src1, id_ex_rd, ex_mem_rd;
    logic [1:0] valid;
    logic       id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic       branch, jump, cmp, perf_clear;

    logic        a_pc, a_ifid, a_nop, a_fl;
    logic [2:0]  a_stall, a_flush;
    logic        b_pc, b_ifid, b_nop, b_fl;
    logic [31:0] b_stall, b_flush;

    hazard_control_unit #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .PERF_W(3)) dut_a (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .if_id_src_in       ({src1, src0}),
        .if_id_src_valid_in (valid),
        .id_ex_rd_in        (id_ex_rd),
        .id_ex_mem_read_in  (id_ex_mem_read),
        .id_ex_reg_write_in (id_ex_reg_write),
        .ex_mem_rd_in       (ex_mem_rd),
        .ex_mem_mem_read_in (ex_mem_mem_read),
        .branch_in          (branch),
        .jump_in            (jump),
        .comparator_in      (cmp),
        .perf_clear_in      (perf_clear),
        .pc_write_out       (a_pc),
        .if_id_write_out    (a_ifid),
        .mux_nop_out        (a_nop),
        .flush_out          (a_fl),
        .stall_cycles_out   (a_stall),
        .flush_cycles_out   (a_flush)
    );

    hazard_control_unit #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .PERF_W(32)) dut_b (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .if_id_src_in       ({src1, src0}),
        .if_id_src_valid_in (valid),
        .id_ex_rd_in        (id_ex_rd),
        .id_ex_mem_read_in  (id_ex_mem_read),
        .id_ex_reg_write_in (id_ex_reg_write),
        .ex_mem_rd_in       (ex_mem_rd),
        .ex_mem_mem_read_in (ex_mem_mem_read),
        .branch_in          (branch),
        .jump_in            (jump),
        .comparator_in      (cmp),
        .perf_clear_in      (perf_clear),
        .pc_write_out       (b_pc),
        .if_id_write_out    (b_ifid),
        .mux_nop_out        (b_nop),
        .flush_out          (b_fl),
        .stall_cycles_out   (b_stall),
        .flush_cycles_out   (b_flush)
    );

    typedef struct packed {
        logic [3:0]  ctl_a;
        logic [3:0]  ctl_b;
        logic [31:0] st_a;
        logic [31:0] fl_a;
        logic [31:0] st_b;
        logic [31:0] fl_b;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int     lat[2]  = '{1, 3};
    int     fcy[2]  = '{1, 2};
    longint pmax[2] = '{7, 64'h0000_0000_FFFF_FFFF};
    int     m_state[2];
    int     m_rem[2];
    int     m_kind[2];
    logic [3:0] m_ctl[2];
    longint m_st[2];
    longint m_fl[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic bit mt(input logic [4:0] rd);
        return (rd != 5'd0) && ((valid[0] && src0 == rd) || (valid[1] && src1 == rd));
    endfunction

    task automatic model_eval(input int i, output logic [3:0] ctl);
        bit hl, hb, rdr;
        int k;
        hl  = id_ex_mem_read && mt(id_ex_rd);
        hb  = branch && !jump && ((id_ex_reg_write && mt(id_ex_rd)) ||
                                  (ex_mem_mem_read && mt(ex_mem_rd)));
        rdr = jump || (branch && cmp && !hb);
        k   = hl ? 1 : hb ? 2 : rdr ? 3 : 0;
        if (!rst_n_in)          ctl = STALL_C;
        else if (m_state[i] == 1) ctl = STALL_C;
        else if (m_state[i] == 2) ctl = FLUSH_C;
        else if (k == 1 || k == 2) ctl = STALL_C;
        else if (k == 3)        ctl = FLUSH_C;
        else                    ctl = NORMAL_C;
        m_kind[i] = k;
        m_ctl[i]  = ctl;
    endtask

    task automatic model_tick(input int i);
        if (!rst_n_in) begin
            m_state[i] = 0; m_rem[i] = 0; m_st[i] = 0; m_fl[i] = 0;
            return;
        end
        if (perf_clear) begin
            m_st[i] = 0; m_fl[i] = 0;
        end else begin
            if (m_ctl[i][3] == 1'b0 && m_st[i] < pmax[i]) m_st[i]++;
            if (m_ctl[i][0] == 1'b1 && m_fl[i] < pmax[i]) m_fl[i]++;
        end
        if (m_state[i] == 0) begin
            if (m_kind[i] == 1 && lat[i] > 1) begin
                m_state[i] = 1; m_rem[i] = lat[i] - 1;
            end else if (m_kind[i] == 3 && fcy[i] > 1) begin
                m_state[i] = 2; m_rem[i] = fcy[i] - 1;
            end
        end else begin
            m_rem[i]--;
            if (m_rem[i] == 0) m_state[i] = 0;
        end
    endtask

    task automatic run_cycle(input string tag);
        exp_t e, g;
        logic [3:0] c0, c1;
        model_eval(0, c0);
        model_eval(1, c1);
        e.ctl_a = c0;
        e.ctl_b = c1;
        e.st_a  = rst_n_in ? 32'(m_st[0]) : 32'd0;
        e.fl_a  = rst_n_in ? 32'(m_fl[0]) : 32'd0;
        e.st_b  = rst_n_in ? 32'(m_st[1]) : 32'd0;
        e.fl_b  = rst_n_in ? 32'(m_fl[1]) : 32'd0;
        exp_q.push_back(e);
        #2;
        g = exp_q.pop_front();
        check_eq({tag, "/a_ctl"},   64'({a_pc, a_ifid, a_nop, a_fl}), 64'(g.ctl_a));
        check_eq({tag, "/b_ctl"},   64'({b_pc, b_ifid, b_nop, b_fl}), 64'(g.ctl_b));
        check_eq({tag, "/a_stall"}, 64'(a_stall), 64'(g.st_a));
        check_eq({tag, "/a_flush"}, 64'(a_flush), 64'(g.fl_a));
        check_eq({tag, "/b_stall"}, 64'(b_stall), 64'(g.st_b));
        check_eq({tag, "/b_flush"}, 64'(b_flush), 64'(g.fl_b));
        @(posedge clk_in);
        model_tick(0);
        model_tick(1);
        #1;
    endtask

    task automatic idle();
        src0 = 0; src1 = 0; valid = 0; id_ex_rd = 0; ex_mem_rd = 0;
        id_ex_mem_read = 0; id_ex_reg_write = 0; ex_mem_mem_read = 0;
        branch = 0; jump = 0; cmp = 0; perf_clear = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_rem[i] = 0; m_st[i] = 0; m_fl[i] = 0;
            m_kind[i] = 0; m_ctl[i] = STALL_C;
        end
        rst_n_in = 1'b0;
        idle();
        @(posedge clk_in);
        #1;
        run_cycle("rst");
        run_cycle("rst2");
        rst_n_in = 1'b1;
        run_cycle("idle");

        // Load-use hazard; B holds the stall while a jump is presented.
        id_ex_mem_read = 1; id_ex_rd = 5; src0 = 5; valid = 2'b01;
        run_cycle("ld");
        idle(); jump = 1;
        run_cycle("ld_jmp1");
        run_cycle("ld_jmp2");
        idle();
        run_cycle("ld_after");

        // Register zero and unread operands never stall.
        id_ex_mem_read = 1; id_ex_rd = 0; src0 = 0; valid = 2'b01;
        run_cycle("rd0");
        id_ex_rd = 5; src0 = 5; src1 = 7; valid = 2'b10;
        run_cycle("novalid");
        idle();

        // Branch-operand hazards, then a taken branch.
        branch = 1; cmp = 1; id_ex_reg_write = 1; id_ex_rd = 8; src1 = 8; valid = 2'b10;
        run_cycle("br_ex");
        id_ex_reg_write = 0;
        run_cycle("br_take");
        idle();
        run_cycle("br_after");
        branch = 1; cmp = 1; ex_mem_mem_read = 1; ex_mem_rd = 3; src0 = 3; valid = 2'b01;
        run_cycle("br_mem");
        jump = 1;
        run_cycle("br_jmp");
        idle();
        run_cycle("idle2");
        run_cycle("idle3");

        // Jump, then a load hazard that B must ignore while flushing.
        jump = 1;
        run_cycle("jmp");
        idle(); id_ex_mem_read = 1; id_ex_rd = 4; src0 = 4; valid = 2'b01;
        run_cycle("jmp_hz");
        idle();
        run_cycle("jmp_after");

        // Reset in the middle of B's flush.
        jump = 1;
        run_cycle("jmp_r");
        idle(); rst_n_in = 1'b0;
        run_cycle("rst_mid");
        rst_n_in = 1'b1;
        run_cycle("rst_rel");

        // Saturate A's 3-bit stall counter, then clear.
        id_ex_mem_read = 1; id_ex_rd = 6; src0 = 6; valid = 2'b01;
        repeat (10) run_cycle("sat");
        idle(); perf_clear = 1;
        run_cycle("clr");
        perf_clear = 0;
        run_cycle("clr_after");

        repeat (60) begin
            src0 = 5'($urandom_range(0, 3)); src1 = 5'($urandom_range(0, 3));
            valid = 2'($urandom_range(0, 3));
            id_ex_rd = 5'($urandom_range(0, 3)); ex_mem_rd = 5'($urandom_range(0, 3));
            id_ex_mem_read = 1'($urandom_range(0, 1)); id_ex_reg_write = 1'($urandom_range(0, 1));
            ex_mem_mem_read = 1'($urandom_range(0, 1));
            branch = 1'($urandom_range(0, 1)); jump = ($urandom_range(0, 3) == 0);
            cmp = 1'($urandom_range(0, 1)); perf_clear = ($urandom_range(0, 15) == 0);
            run_cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
